// File: rtl/up_counter.sv
// Enable-gated BITS-wide binary up counter used as the PWM time base.
// Q updates one clk after en is sampled high and wraps modulo 2^BITS; tc flags the cycle before the wrap.
module up_counter #(
  parameter int unsigned BITS = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  output logic [BITS-1:0] Q,
  output logic            tc
);

  localparam logic [BITS-1:0] CNT_MAX = '1;
  localparam logic [BITS-1:0] CNT_ONE = BITS'(1);

  logic [BITS-1:0] cnt_q;
  logic [BITS-1:0] cnt_d;

  // The carry out of the BITS-wide add is dropped, giving the natural wrap to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Q  = cnt_q;
  assign tc = en && (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_up_counter.sv
// Directed bench for up_counter at BITS=4: reset, hold, count/wrap, tc, gating, async reset mid-count.
module tb_up_counter;

  localparam int unsigned BITS = 4;

  logic            clk;
  logic            rstn;
  logic            en;
  logic [BITS-1:0] Q;
  logic            tc;

  int checks;
  int errors;

  up_counter #(.BITS(BITS)) dut (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .Q    (Q),
    .tc   (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    logic [31:0] exp_q;
    checks = 0;
    errors = 0;
    rstn   = 1'b1;
    en     = 1'b0;

    // Reset asserted before the first rising edge must clear Q on its own.
    #2 rstn = 1'b0;
    #1;
    check("reset_async_q", 32'(Q), 32'd0);
    check("reset_async_tc", 32'(tc), 32'd0);

    en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_held_q", 32'(Q), 32'd0);
    check("reset_held_tc", 32'(tc), 32'd0);
    en   = 1'b0;
    rstn = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_after_reset_q", 32'(Q), 32'd0);
    end

    en = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      exp_q = 32'(i % 16);
      check("count_wrap_q", 32'(Q), exp_q);
      check("count_wrap_tc", 32'(tc), (exp_q == 32'd15) ? 32'd1 : 32'd0);
    end

    @(negedge clk);
    check("tc_at_max_q", 32'(Q), 32'd15);
    check("tc_at_max_tc", 32'(tc), 32'd1);
    en = 1'b0;
    #1;
    check("tc_en_low_at_max", 32'(tc), 32'd0);
    @(negedge clk);
    check("hold_at_max_q", 32'(Q), 32'd15);
    check("hold_at_max_tc", 32'(tc), 32'd0);

    en = 1'b1;
    @(negedge clk);
    check("wrap_after_hold_q", 32'(Q), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("count_to_five_q", 32'(Q), 32'(i));
    end

    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("gate_hold_q", 32'(Q), 32'd5);
    end
    en = 1'b1;
    @(negedge clk);
    check("gate_resume_q", 32'(Q), 32'd6);

    for (int i = 7; i <= 9; i++) begin
      @(negedge clk);
      check("count_to_nine_q", 32'(Q), 32'(i));
    end

    // Pulse reset entirely between edges while counting.
    #2 rstn = 1'b0;
    #1;
    check("midcount_reset_q", 32'(Q), 32'd0);
    check("midcount_reset_tc", 32'(tc), 32'd0);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("resume_after_reset_q", 32'(Q), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
